// File: rtl/spi_ram_responder.sv
// SPI mode-0 target emulating a 23LC-style serial SRAM (READ/WRITE, 16-bit address, auto-increment).
// Every SPI pin is oversampled on clk12MHz; no SPI signal is used as a clock.
`timescale 1ns/1ps
module spi_ram_responder #(
  parameter int         ADDR_BITS = 8,
  parameter logic [7:0] READ_CMD  = 8'h03,
  parameter logic [7:0] WRITE_CMD = 8'h02
) (
  input  logic clk12MHz,
  input  logic rstn,
  input  logic spi_select,
  input  logic spi_clk_in,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic spi_miso_oe,
  output logic busy,
  output logic cmd_error
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_RD_DATA,
    ST_WR_DATA,
    ST_IGNORE
  } state_t;

  state_t         state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     rx_sh_q, rx_sh_d;
  logic [7:0]     tx_sh_q, tx_sh_d;
  logic [15:0]    addr_q, addr_d;
  logic           rd_dir_q, rd_dir_d;
  logic           miso_q, miso_d;
  logic           miso_oe_q, miso_oe_d;
  logic           cmd_err_q, cmd_err_d;

  logic           sel_s1_q, sel_s2_q, sel_s3_q;
  logic           sck_s1_q, sck_s2_q, sck_s3_q;
  logic           mosi_s1_q, mosi_s2_q;

  logic [7:0]           mem_q [DEPTH];
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_widx;
  logic [ADDR_BITS-1:0] rd_idx;
  logic [7:0]           mem_rdata;

  logic        sel_fall, sel_rise, sck_rise, sck_fall;
  logic [7:0]  rx_byte;
  logic [15:0] addr_full;

  // Auto-increment only touches the implemented bits so the wrap is modulo the depth.
  function automatic logic [15:0] next_addr(input logic [15:0] a);
    logic [15:0] n;
    n = a;
    n[ADDR_BITS-1:0] = a[ADDR_BITS-1:0] + ADDR_BITS'(1);
    return n;
  endfunction

  assign sel_fall  = sel_s3_q & ~sel_s2_q;
  assign sel_rise  = ~sel_s3_q & sel_s2_q;
  assign sck_rise  = ~sck_s3_q & sck_s2_q;
  assign sck_fall  = sck_s3_q & ~sck_s2_q;
  assign rx_byte   = {rx_sh_q[6:0], mosi_s2_q};
  assign addr_full = {addr_q[15:8], rx_byte};

  // The first read byte is fetched from the address still being assembled.
  assign rd_idx    = (state_q == ST_ADDR_LO) ? addr_full[ADDR_BITS-1:0] : addr_q[ADDR_BITS-1:0];
  assign mem_rdata = mem_q[rd_idx];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_sh_d   = rx_sh_q;
    tx_sh_d   = tx_sh_q;
    addr_d    = addr_q;
    rd_dir_d  = rd_dir_q;
    miso_d    = miso_q;
    miso_oe_d = miso_oe_q;
    cmd_err_d = 1'b0;
    mem_we    = 1'b0;
    mem_widx  = addr_q[ADDR_BITS-1:0];

    case (state_q)
      ST_IDLE: begin
        if (sel_fall) begin
          state_d   = ST_CMD;
          bit_cnt_d = 3'd0;
        end
      end
      ST_CMD: begin
        if (sck_rise) begin
          rx_sh_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (rx_byte == READ_CMD || rx_byte == WRITE_CMD) begin
              rd_dir_d = (rx_byte == READ_CMD);
              state_d  = ST_ADDR_HI;
            end else begin
              cmd_err_d = 1'b1;
              state_d   = ST_IGNORE;
            end
          end
        end
      end
      ST_ADDR_HI: begin
        if (sck_rise) begin
          rx_sh_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            addr_d[15:8] = rx_byte;
            state_d      = ST_ADDR_LO;
          end
        end
      end
      ST_ADDR_LO: begin
        if (sck_rise) begin
          rx_sh_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (rd_dir_q) begin
              tx_sh_d = mem_rdata;
              addr_d  = next_addr(addr_full);
              state_d = ST_RD_DATA;
            end else begin
              addr_d  = addr_full;
              state_d = ST_WR_DATA;
            end
          end
        end
      end
      ST_RD_DATA: begin
        // Bit counter tracks presented bits here; the byte after the current one is loaded on the 8th fall.
        if (sck_fall) begin
          miso_oe_d = 1'b1;
          miso_d    = tx_sh_q[7];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            tx_sh_d = mem_rdata;
            addr_d  = next_addr(addr_q);
          end else begin
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
          end
        end
      end
      ST_WR_DATA: begin
        if (sck_rise) begin
          rx_sh_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            mem_we = 1'b1;
            addr_d = next_addr(addr_q);
          end
        end
      end
      ST_IGNORE: begin
      end
      default: state_d = ST_IDLE;
    endcase

    // Deselect wins over everything except a write committed in the same cycle.
    if (sel_rise) begin
      state_d   = ST_IDLE;
      miso_d    = 1'b0;
      miso_oe_d = 1'b0;
      bit_cnt_d = 3'd0;
    end
  end

  always_ff @(posedge clk12MHz or negedge rstn) begin
    if (!rstn) begin
      sel_s1_q  <= 1'b1;
      sel_s2_q  <= 1'b1;
      sel_s3_q  <= 1'b1;
      sck_s1_q  <= 1'b0;
      sck_s2_q  <= 1'b0;
      sck_s3_q  <= 1'b0;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
      state_q   <= ST_IDLE;
      bit_cnt_q <= 3'd0;
      rx_sh_q   <= 8'h00;
      tx_sh_q   <= 8'h00;
      addr_q    <= 16'h0000;
      rd_dir_q  <= 1'b0;
      miso_q    <= 1'b0;
      miso_oe_q <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      sel_s1_q  <= spi_select;
      sel_s2_q  <= sel_s1_q;
      sel_s3_q  <= sel_s2_q;
      sck_s1_q  <= spi_clk_in;
      sck_s2_q  <= sck_s1_q;
      sck_s3_q  <= sck_s2_q;
      mosi_s1_q <= spi_mosi;
      mosi_s2_q <= mosi_s1_q;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_sh_q   <= rx_sh_d;
      tx_sh_q   <= tx_sh_d;
      addr_q    <= addr_d;
      rd_dir_q  <= rd_dir_d;
      miso_q    <= miso_d;
      miso_oe_q <= miso_oe_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  // Storage is deliberately left out of reset; mem_we is low whenever the FSM is held in IDLE.
  always_ff @(posedge clk12MHz) begin
    if (mem_we) begin
      mem_q[mem_widx] <= rx_byte;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = miso_oe_q;
  assign busy        = (state_q != ST_IDLE);
  assign cmd_error   = cmd_err_q;

endmodule

// File: doc/spi_ram_responder.md
Name: spi_ram_responder

Overview:
- SPI mode-0 target that emulates a 23LC-style serial SRAM. It is the far end of the bus driven by the SPI RAM controller.
- It lets the controller and demo top run in simulation and on-board without an external RAM chip.
- All logic is synchronous to the 12 MHz system clock. SPI pins are oversampled, not used as clocks.
- Supported commands: READ (0x03) and WRITE (0x02), each followed by a 16-bit address and sequential data with auto-increment.

Parameters:
- ADDR_BITS, 8, number of implemented address bits; memory depth is 2**ADDR_BITS bytes.
- READ_CMD, 8'h03, opcode for sequential read.
- WRITE_CMD, 8'h02, opcode for sequential write.

Ports:
- clk12MHz  input  1  system clock; the only clock in the block.
- rstn  input  1  asynchronous active-low reset.
- spi_select  input  1  chip select from initiator, active low.
- spi_clk_in  input  1  SCK from initiator, idle low, max clk12MHz/4.
- spi_mosi  input  1  data from initiator, MSB first.
- spi_miso  output  1  data to initiator, MSB first.
- spi_miso_oe  output  1  high while the block drives MISO (read data phase only).
- busy  output  1  high while spi_select (synchronised) is low.
- cmd_error  output  1  one-cycle pulse when an unsupported opcode is received.

Behaviour:
- Reset (async, rstn low):
  - state=IDLE; spi_miso=0, spi_miso_oe=0, busy=0, cmd_error=0; bit counter and address cleared.
  - Memory contents are not reset.
- Synchronisation:
  - spi_select, spi_clk_in and spi_mosi each pass through a 2-flop synchroniser.
  - SCK rise and fall are detected from the synchronised previous/current values.
  - Latency from a pin change to the internal event is 2-3 clk12MHz cycles.
- SPI mode 0:
  - MOSI is sampled on SCK rising edges.
  - MISO changes only on SCK falling edges, with one exception: the first bit of each read byte is presented on the falling edge that follows the last address bit.
- State machine (bit counter 0..7 counts sampled bits within a byte):
  - IDLE: on select falling, go to CMD with counter=0 and busy=1.
  - CMD: shift 8 bits. On the 8th rise:
    - opcode==READ_CMD or WRITE_CMD: latch direction, go to ADDR_HI.
    - otherwise: pulse cmd_error, go to IGNORE.
  - ADDR_HI: shift 8 bits into addr[15:8], then go to ADDR_LO.
  - ADDR_LO: shift 8 bits into addr[7:0]. On the 8th rise, go to RD_DATA or WR_DATA. For reads, issue the memory read of addr[ADDR_BITS-1:0] in the same cycle.
  - RD_DATA:
    - On each fall: set spi_miso_oe=1 and drive the next shift-register bit.
    - After 8 bits, load the next byte.
    - Address increments after each byte is loaded.
    - Next byte is prefetched so MISO never stalls at SCK = clk12MHz/4.
  - WR_DATA:
    - Shift MOSI on each rise.
    - On the 8th rise, write the byte to mem[addr[ADDR_BITS-1:0]] and increment the address.
  - IGNORE: no MISO drive, no memory access; remain until select rises.
- Address rules:
  - Only addr[ADDR_BITS-1:0] indexes memory; upper bits are ignored.
  - Increment wraps modulo 2**ADDR_BITS (0xFF to 0x00 when ADDR_BITS=8).
- select rising from any state (synchronised):
  - Return to IDLE; spi_miso_oe=0, spi_miso=0, busy=0, counter=0.
  - A partially shifted write byte (<8 bits) is discarded; bytes already committed remain.
- select low with no SCK activity: state holds indefinitely.
- SCK edges while select high: ignored.
- Simultaneous select rise and 8th SCK rise in WR_DATA (same cycle): the write is committed first, then the block enters IDLE.
- Reset asserted mid-transfer: immediate IDLE. MISO is released within the reset assertion (async). No memory write occurs in that cycle.

Test Plan:
- Write/read-back: WRITE 0x0010, data 0xA5 0x3C, then READ 0x0010 for 2 bytes -> MISO returns 0xA5 then 0x3C; spi_miso_oe high only during the 16 data bits; busy tracks select.
- Wrap-around: WRITE 0x00FF, data 0x11 0x22, then READ 0x0000 for 1 byte -> 0x22; READ 0x00FF -> 0x11.
- Upper address ignored (ADDR_BITS=8): after the write/read-back test, READ 0x1210 -> 0xA5, same as address 0x0010.
- Bad opcode: send 0x9F plus 3 bytes -> cmd_error high exactly 1 cycle after the 8th bit; spi_miso_oe stays 0; a following READ 0x0010 still returns 0xA5.
- Abort mid-byte: WRITE 0x0010, data 0xFF, then 4 bits of 0x00, then deassert select -> READ 0x0010 for 2 bytes returns 0xFF, 0x3C (partial byte not written).
- Reset mid-read: assert rstn low during the 5th data bit of a READ -> spi_miso=0 and spi_miso_oe=0 within 1 cycle; after release, a READ 0x0010 works normally and returns 0xFF.
